keypad_scan: RTL and testbench

- Matrix-keypad front end that produces the digit/confirm/cancel key stream consumed by the lock controllers.
- Drives the four columns of a 4x4 keypad one at a time and samples the four rows.
- Debounces each press and emits exactly one single-cycle strobe per press.
- Sits between the board keypad pins and the `din`/`confirm`/`cancel` inputs of the lock logic.

---
 rtl/keypad_scan.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_scan.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with a per-press debounce.
// Drives one column at a time, debounces each press and each release,
// and emits one registered strobe per accepted key:
//   digits -> din/key_valid, '#' -> confirm, '*' -> cancel.
// Optional build macro KEYPAD_HEX_EN: when defined, keys A..D are also
// reported on din (10..13) with key_valid; otherwise they are tracked
// but produce no strobe.
module keypad_scan #(
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] din,
    output logic       key_valid,
    output logic       confirm,
    output logic       cancel
);

    localparam int unsigned DW = 10;
    localparam int unsigned CW = 4;
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE);
    localparam logic [3:0]    CODE_STAR = 4'hE;
    localparam logic [3:0]    CODE_HASH = 4'hF;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] dwell;
    logic          sample;
    logic [CW-1:0] cnt, cnt_n, rcnt, rcnt_n;
    logic [1:0]    col, col_n, lrow, lrow_n;
    logic [3:0]    blocked, blocked_n;
    logic [3:0]    col_out_n, din_n;
    logic          key_valid_n, confirm_n, cancel_n;
    logic          one_low;
    logic [1:0]    low_row;
    logic [3:0]    code;
    logic          advance;

    // Key position {row, col} to code; '*' and '#' use the internal codes E/F.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0:    k = 4'h1;
            4'h1:    k = 4'h2;
            4'h2:    k = 4'h3;
            4'h3:    k = 4'hA;
            4'h4:    k = 4'h4;
            4'h5:    k = 4'h5;
            4'h6:    k = 4'h6;
            4'h7:    k = 4'hB;
            4'h8:    k = 4'h7;
            4'h9:    k = 4'h8;
            4'hA:    k = 4'h9;
            4'hB:    k = 4'hC;
            4'hC:    k = CODE_STAR;
            4'hD:    k = 4'h0;
            4'hE:    k = CODE_HASH;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Two-flop synchronizer for the asynchronous rows (idle = all high).
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    // Column dwell counter; a sample is taken on its last count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) dwell <= '0;
        else     dwell <= sample ? '0 : dwell + DW'(1);
    end

    assign sample = (dwell == DWELL_MAX);

    // Exactly-one-row-low detection on the synchronized rows.
    always_comb begin
        one_low = 1'b1;
        low_row = 2'd0;
        case (row_s2)
            4'b1110: low_row = 2'd0;
            4'b1101: low_row = 2'd1;
            4'b1011: low_row = 2'd2;
            4'b0111: low_row = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    assign code = key_code(lrow, col);

    // Next-state, counters, column and strobe decode.
    // After a release every column is blocked until it is seen with all rows
    // high, so keys held across another key's press are never reported.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rcnt_n      = rcnt;
        lrow_n      = lrow;
        blocked_n   = blocked;
        advance     = 1'b0;
        din_n       = 4'hF;
        key_valid_n = 1'b0;
        confirm_n   = 1'b0;
        cancel_n    = 1'b0;
        if (sample) begin
            case (state)
                ST_SCAN: begin
                    if (row_s2 == 4'hF) blocked_n[col] = 1'b0;
                    if (one_low && !blocked[col]) begin
                        lrow_n  = low_row;
                        cnt_n   = CW'(1);
                        state_n = ST_DEBOUNCE;
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (one_low && (low_row == lrow)) begin
                        cnt_n = (cnt < DEB_MAX) ? cnt + CW'(1) : cnt;
                        if (cnt_n == DEB_MAX) begin
                            state_n = ST_PRESSED;
                            rcnt_n  = '0;
                            if (code == CODE_STAR) begin
                                cancel_n = 1'b1;
                            end else if (code == CODE_HASH) begin
                                confirm_n = 1'b1;
                            end else if (code >= 4'hA) begin
`ifdef KEYPAD_HEX_EN
                                din_n       = code;
                                key_valid_n = 1'b1;
`else
                                din_n       = 4'hF;
`endif
                            end else begin
                                din_n       = code;
                                key_valid_n = 1'b1;
                            end
                        end
                    end else begin
                        state_n = ST_SCAN;
                        cnt_n   = '0;
                        advance = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (row_s2[lrow]) begin
                        rcnt_n = (rcnt < DEB_MAX) ? rcnt + CW'(1) : rcnt;
                        if (rcnt_n == DEB_MAX) begin
                            state_n   = ST_SCAN;
                            rcnt_n    = '0;
                            cnt_n     = '0;
                            blocked_n = 4'hF;
                            advance   = 1'b1;
                        end
                    end else begin
                        rcnt_n = '0;
                    end
                end
                default: begin
                    state_n = ST_SCAN;
                    cnt_n   = '0;
                    rcnt_n  = '0;
                end
            endcase
        end
        col_n     = advance ? col + 2'd1 : col;
        col_out_n = ~(4'b0001 << col_n);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= ST_SCAN;
            cnt       <= '0;
            rcnt      <= '0;
            lrow      <= 2'd0;
            col       <= 2'd0;
            blocked   <= 4'h0;
            col_out   <= 4'b1110;
            din       <= 4'hF;
            key_valid <= 1'b0;
            confirm   <= 1'b0;
            cancel    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rcnt      <= rcnt_n;
            lrow      <= lrow_n;
            col       <= col_n;
            blocked   <= blocked_n;
            col_out   <= col_out_n;
            din       <= din_n;
            key_valid <= key_valid_n;
            confirm   <= confirm_n;
            cancel    <= cancel_n;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: scoreboard bench for keypad_scan (SCAN_DIV=4, DEBOUNCE=3).
// A small keypad model turns held keys plus col_out into row_in.
// Build with KEYPAD_HEX_EN defined to exercise the hex-key variant.
module tb_keypad_scan;

    localparam int unsigned SD  = 4;
    localparam int unsigned DEB = 3;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] row_in, col_out, din;
    logic       key_valid, confirm, cancel;

    logic [3:0] pressed [4];   // pressed[row] = columns held in that row

    typedef struct {
        logic [6:0] ev;        // {key_valid, confirm, cancel, din}
        int         cyc;       // expected strobe cycle, -1 = any
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
        .clk(clk), .clr(clr), .row_in(row_in), .col_out(col_out),
        .din(din), .key_valid(key_valid), .confirm(confirm), .cancel(cancel)
    );

    always #5 clk = ~clk;

    // Keypad model: a row reads low when a held key sits in a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r] & ~col_out);
    end

    // Cycle count since the last reset release.
    always @(posedge clk or posedge clr) begin
        if (clr) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Strobes are popped against the scoreboard; idle cycles must show din=F.
    always @(negedge clk) begin : monitor
        logic [6:0] got;
        exp_t       e;
        if (!clr) begin
            got = {key_valid, confirm, cancel, din};
            if (key_valid || confirm || cancel) begin
                if (sbq.size() == 0) begin
                    check_eq("unexpected_strobe", int'(got), 0);
                end else begin
                    e = sbq.pop_front();
                    check_eq("strobe_code", int'(got), int'(e.ev));
                    if (e.cyc >= 0) check_eq("strobe_cycle", cyc, e.cyc);
                end
            end else begin
                check_eq("idle_din", int'(din), 4'hF);
            end
        end
    end

    task automatic key(input int r, input int c, input logic down);
        pressed[r][c] = down;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input logic kv, input logic cf, input logic cn,
                             input logic [3:0] d, input int at);
        exp_t e;
        e.ev  = {kv, cf, cn, d};
        e.cyc = at;
        sbq.push_back(e);
    endtask

    // Wait (bounded) for the first cycle of a given column drive.
    task automatic wait_col(input logic [3:0] target, output int t);
        int found = 0;
        t = -1;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            if (col_out == target && (cyc % SD) == 0) begin
                found = 1;
                t = cyc;
            end
        end
        check_eq("wait_col", found, 1);
    endtask

    initial begin : stim
        int         t;
        int         tcol;
        logic [3:0] seen;
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
        clr = 1'b1;
        idle(3);
        check_eq("rst_col", int'(col_out), 4'b1110);
        check_eq("rst_din", int'(din), 4'hF);
        check_eq("rst_strb", int'({key_valid, confirm, cancel}), 0);
        clr = 1'b0;

        // Reset in the middle of debouncing '6' (column 2).
        key(1, 2, 1'b1);
        idle(14);
        check_eq("mid_col", int'(col_out), 4'b1011);
        clr = 1'b1;
        key(1, 2, 1'b0);
        #1;
        check_eq("midrst_col", int'(col_out), 4'b1110);
        check_eq("midrst_din", int'(din), 4'hF);
        check_eq("midrst_strb", int'({key_valid, confirm, cancel}), 0);
        idle(2);
        clr = 1'b0;
        idle(1);
        check_eq("restart_col0", int'(col_out), 4'b1110);
        idle(SD);
        check_eq("restart_col1", int'(col_out), 4'b1101);
        idle(40);

        // Clean press of '5', held 100 cycles, with latency check.
        wait_col(4'b1110, t);
        key(1, 1, 1'b1);
        wait_col(4'b1101, tcol);
        expect_ev(1'b1, 1'b0, 1'b0, 4'h5, tcol + SD - 1 + (DEB - 1) * SD + 1);
        idle(40);
        check_eq("held_col", int'(col_out), 4'b1101);
        idle(56);
        key(1, 1, 1'b0);
        idle(60);

        // '#' then '*'.
        expect_ev(1'b0, 1'b1, 1'b0, 4'hF, -1);
        key(3, 2, 1'b1);
        idle(40);
        key(3, 2, 1'b0);
        idle(40);
        expect_ev(1'b0, 1'b0, 1'b1, 4'hF, -1);
        key(3, 0, 1'b1);
        idle(40);
        key(3, 0, 1'b0);
        idle(40);

        // Bounce on '1': one high sample aborts; re-acquired on the next visit.
        wait_col(4'b1110, t);
        expect_ev(1'b1, 1'b0, 1'b0, 4'h1, t + (5 + DEB) * SD);
        key(0, 0, 1'b1);
        idle(SD);
        key(0, 0, 1'b0);
        idle(SD);
        key(0, 0, 1'b1);
        idle(40);
        key(0, 0, 1'b0);
        idle(40);

        // '2' and '8' together: no strobe, columns keep rotating.
        key(0, 1, 1'b1);
        key(2, 1, 1'b1);
        seen = 4'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | ~col_out;
        end
        check_eq("two_rows_rotate", int'(seen), 4'hF);
        key(0, 1, 1'b0);
        key(2, 1, 1'b0);
        idle(40);

        // 'A' held: column 3 stays driven while it is down.
`ifdef KEYPAD_HEX_EN
        expect_ev(1'b1, 1'b0, 1'b0, 4'hA, -1);
`endif
        key(0, 3, 1'b1);
        idle(40);
        for (int i = 0; i < 4; i++) begin
            check_eq("a_col_frozen", int'(col_out), 4'b0111);
            idle(5);
        end
        key(0, 3, 1'b0);
        idle(60);

        check_eq("sb_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
